// File: rtl/ps2_kbd_decoder.sv
// PS/2 Set-2 keyboard decoder: turns received bytes into key events held in a small FWFT FIFO,
// and runs the ED/<leds> command handshake to update the keyboard LEDs.
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic [2:0] led_state,
  input  logic       led_update,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_pop,
  output logic       overrun,
  output logic       cmd_busy,
  output logic       cmd_error
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_ED = 8'hED;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;

  typedef enum logic [2:0] {P_IDLE, P_E0, P_F0, P_E0F0, P_SKIP} parse_state_t;
  typedef enum logic [2:0] {
    C_IDLE, C_SEND_ED, C_WAIT_ACK1, C_WAIT_FA1, C_SEND_LED, C_WAIT_ACK2, C_WAIT_FA2
  } cmd_state_t;

  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  parse_state_t p_state_q;
  cmd_state_t   c_state_q;
  logic [2:0]   skip_q;
  logic         ev_vld_q;
  logic [9:0]   ev_q;

  // ACK/NAK bytes belong to the command FSM while it is waiting for them.
  logic cmd_wait_fa;
  logic cmd_take;
  logic par_vld;
  assign cmd_wait_fa = (c_state_q == C_WAIT_FA1) || (c_state_q == C_WAIT_FA2);
  assign cmd_take    = rx_ready && cmd_wait_fa && ((rx_data == B_FA) || (rx_data == B_FE));
  assign par_vld     = rx_ready && !cmd_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q <= P_IDLE;
      skip_q    <= 3'd0;
      ev_vld_q  <= 1'b0;
      ev_q      <= 10'd0;
    end else begin
      ev_vld_q <= 1'b0;
      if (par_vld) begin
        case (p_state_q)
          P_IDLE: begin
            if (rx_data == B_E0) begin
              p_state_q <= P_E0;
            end else if (rx_data == B_F0) begin
              p_state_q <= P_F0;
            end else if (rx_data == B_E1) begin
              skip_q    <= 3'd7;
              p_state_q <= P_SKIP;
            end else if (!is_status(rx_data)) begin
              ev_vld_q <= 1'b1;
              ev_q     <= {2'b00, rx_data};
            end
          end
          P_E0: begin
            if (rx_data == B_F0) begin
              p_state_q <= P_E0F0;
            end else if (is_status(rx_data)) begin
              p_state_q <= P_IDLE;
            end else if (rx_data != B_E0) begin
              ev_vld_q  <= 1'b1;
              ev_q      <= {2'b10, rx_data};
              p_state_q <= P_IDLE;
            end
          end
          P_F0: begin
            if (!is_status(rx_data)) begin
              ev_vld_q <= 1'b1;
              ev_q     <= {2'b01, rx_data};
            end
            p_state_q <= P_IDLE;
          end
          P_E0F0: begin
            if (!is_status(rx_data)) begin
              ev_vld_q <= 1'b1;
              ev_q     <= {2'b11, rx_data};
            end
            p_state_q <= P_IDLE;
          end
          P_SKIP: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
              skip_q    <= 3'd0;
              p_state_q <= P_IDLE;
            end
          end
          default: p_state_q <= P_IDLE;
        endcase
      end
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic          fifo_full;
  logic          pop_en;
  logic          push_en;

  assign fifo_full = (count_q == FULL_CNT);
  assign pop_en    = key_pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_en   = ev_vld_q && (!fifo_full || pop_en);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= 10'd0;
        end else if (push_en && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= ev_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
      if (ev_vld_q && !push_en) overrun_q <= 1'b1;
    end
  end

  assign {key_ext, key_break, key_code} = mem_q[rd_ptr_q];
  assign key_valid = (count_q != '0);
  assign overrun   = overrun_q;

  logic [7:0]    tx_data_q;
  logic          tx_req_q;
  logic          cmd_error_q;
  logic [7:0]    led_byte_q;
  logic [TW-1:0] tmo_q;
  logic          pend_q;
  logic [2:0]    pend_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_state_q   <= C_IDLE;
      tx_data_q   <= 8'h00;
      tx_req_q    <= 1'b0;
      cmd_error_q <= 1'b0;
      led_byte_q  <= 8'h00;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= 3'b000;
    end else begin
      cmd_error_q <= 1'b0;
      if (led_update) begin
        pend_q     <= 1'b1;
        pend_val_q <= led_state;
      end
      case (c_state_q)
        C_IDLE: begin
          if (pend_q) begin
            if (!led_update) pend_q <= 1'b0;
            led_byte_q <= {5'b00000, pend_val_q};
            c_state_q  <= C_SEND_ED;
          end
        end
        C_SEND_ED: begin
          tx_data_q <= B_ED;
          tx_req_q  <= 1'b1;
          tmo_q     <= TMO_LOAD;
          c_state_q <= C_WAIT_ACK1;
        end
        C_SEND_LED: begin
          tx_data_q <= led_byte_q;
          tx_req_q  <= 1'b1;
          tmo_q     <= TMO_LOAD;
          c_state_q <= C_WAIT_ACK2;
        end
        C_WAIT_ACK1, C_WAIT_ACK2: begin
          if (tx_ready) begin
            tx_req_q  <= 1'b0;
            tmo_q     <= TMO_LOAD;
            c_state_q <= (c_state_q == C_WAIT_ACK1) ? C_WAIT_FA1 : C_WAIT_FA2;
          end else if (tmo_q == '0) begin
            tx_req_q    <= 1'b0;
            cmd_error_q <= 1'b1;
            c_state_q   <= C_IDLE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        C_WAIT_FA1, C_WAIT_FA2: begin
          if (rx_ready && (rx_data == B_FA)) begin
            c_state_q <= (c_state_q == C_WAIT_FA1) ? C_SEND_LED : C_IDLE;
          end else if ((rx_ready && (rx_data == B_FE)) || (tmo_q == '0)) begin
            tx_req_q    <= 1'b0;
            cmd_error_q <= 1'b1;
            c_state_q   <= C_IDLE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        default: c_state_q <= C_IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign cmd_error = cmd_error_q;
  assign cmd_busy  = (c_state_q != C_IDLE);

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: stimulus pushes expected events, a monitor pops and compares.
module tb_ps2_kbd_decoder;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [2:0] led_state;
  logic       led_update;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_pop;
  logic       overrun;
  logic       cmd_busy;
  logic       cmd_error;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  bit         auto_pop = 1'b1;

  always #5 clk = ~clk;

  ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .led_state(led_state), .led_update(led_update),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
    .key_pop(key_pop), .overrun(overrun), .cmd_busy(cmd_busy), .cmd_error(cmd_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // kind: 0 tx_req high, 1 tx_req low, 2 cmd_error pulse, 3 all expected events drained
  task automatic wait_cond(input int kind, input int lim, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      case (kind)
        0:       ok = (tx_req === 1'b1);
        1:       ok = (tx_req === 1'b0);
        2:       ok = (cmd_error === 1'b1);
        default: ok = (exp_q.size() == 0) && (key_valid === 1'b0);
      endcase
      if (ok) break;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got no condition within %0d cycles, required condition met", name, lim);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic ev(input logic e, input logic b, input logic [7:0] c);
    exp_q.push_back({e, b, c});
  endtask

  task automatic led_req(input logic [2:0] v);
    @(negedge clk);
    led_state  = v;
    led_update = 1'b1;
    @(negedge clk);
    led_update = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  // Monitor: owns key_pop while auto_pop is set.
  initial begin
    logic [9:0] exp_ev;
    key_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_pop) begin
        key_pop = 1'b0;
        if (!rst && key_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got 0x%0h, required none", {key_ext, key_break, key_code});
          end else begin
            exp_ev = exp_q.pop_front();
            chk("event", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_ev});
            $display("event ext=%0b brk=%0b code=%02h (expected %03h)", key_ext, key_break, key_code, exp_ev);
          end
          key_pop = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] head;
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; tx_ready = 1'b0;
    led_state = 3'b000; led_update = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_word", {key_ext, key_break, key_code}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cmd_busy", cmd_busy, 0);
    chk("rst_cmd_error", cmd_error, 0);
    rst = 1'b0;

    // Make then break
    ev(0, 0, 8'h1C); ev(0, 1, 8'h1C);
    send(8'h1C); send(8'hF0); send(8'h1C);
    wait_cond(3, 50, "drain_make_break");
    chk("valid_after_pops", key_valid, 0);

    // Extended make/break, status discard, E0+status abort, Pause swallow
    ev(1, 0, 8'h75); ev(1, 1, 8'h75); ev(0, 0, 8'h29);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hE0); send(8'hAA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29);
    wait_cond(3, 80, "drain_ext_pause");

    // Overrun: five makes into a 4-deep FIFO with no pops
    auto_pop = 1'b0;
    chk("overrun_before", overrun, 0);
    for (int c = 1; c <= 5; c++) begin
      if (c <= DEPTH) ev(0, 0, 8'(c));
      send(8'(c));
    end
    repeat (3) @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("full_valid", key_valid, 1);
    // Push of 06 and pop of the head hit the same edge while full
    @(negedge clk);
    rx_data = 8'h06; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    key_pop  = 1'b1;
    head = exp_q.pop_front();
    chk("full_head", {22'd0, key_ext, key_break, key_code}, {22'd0, head});
    $display("event ext=%0b brk=%0b code=%02h (manual pop)", key_ext, key_break, key_code);
    @(negedge clk);
    key_pop = 1'b0;
    ev(0, 0, 8'h06);
    chk("overrun_sticky", overrun, 1);
    auto_pop = 1'b1;
    wait_cond(3, 50, "drain_after_full");

    // LED update 101: ED, FA, 05, FA
    led_req(3'b101);
    wait_cond(0, 10, "ed_req_rise");
    chk("ed_byte", tx_data, 8'hED);
    chk("busy_during_cmd", cmd_busy, 1);
    ack_pulse();
    wait_cond(1, 5, "ed_req_drop");
    send(8'hFA);
    wait_cond(0, 10, "led_req_rise");
    chk("led_byte", tx_data, 8'h05);
    ack_pulse();
    send(8'hFA);
    @(negedge clk);
    chk("busy_after_cmd", cmd_busy, 0);
    chk("no_key_from_cmd", key_valid, 0);

    // NAK in C_WAIT_FA1
    led_req(3'b010);
    wait_cond(0, 10, "fe_req_rise");
    ack_pulse();
    send(8'hFE);
    wait_cond(2, 3, "fe_abort_error");
    @(negedge clk);
    chk("fe_error_one_cycle", cmd_error, 0);
    chk("fe_busy", cmd_busy, 0);

    // No ACK at all
    led_req(3'b001);
    wait_cond(0, 10, "tmo_req_rise");
    wait_cond(2, TMO + 10, "ack_timeout_error");
    @(negedge clk);
    chk("tmo_busy", cmd_busy, 0);
    chk("tmo_tx_req", tx_req, 0);

    // Reset in C_WAIT_ACK2 with two events queued
    auto_pop = 1'b0;
    send(8'h11); send(8'h12);
    repeat (3) @(negedge clk);
    chk("queued_before_rst", key_valid, 1);
    led_req(3'b111);
    wait_cond(0, 10, "rst_ed_rise");
    ack_pulse();
    send(8'hFA);
    wait_cond(0, 10, "rst_led_rise");
    chk("rst_led_byte", tx_data, 8'h07);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_req", tx_req, 0);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_cmd_busy", cmd_busy, 0);
    chk("midrst_overrun", overrun, 0);
    rst = 1'b0;
    auto_pop = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", key_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Consumes the received byte stream of the PS/2 host interface (`rx_data`/`rx_ready`) and decodes Set-2 scan-code sequences into key events: code, extended flag and make/break flag. Events are buffered in a small first-word-fall-through (FWFT) FIFO. The block also drives the host's transmit side (`tx_data`/`tx_req`/`tx_ready`) to update the keyboard LEDs, which requires the ED/FA command handshake. It sits directly downstream of the PS/2 host and upstream of whatever consumes keystrokes.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO depth. Power of two, ≥2.
- `ACK_TIMEOUT`, default 1_000_000: clk cycles allowed in any command wait state before abort.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: byte from the PS/2 host. Valid while `rx_ready`=1.
- `rx_ready` in 1: one-cycle pulse, byte received.
- `tx_ready` in 1: one-cycle pulse, device ACKed the transmitted byte.
- `tx_data` out 8: byte to transmit. Held stable while `tx_req`=1.
- `tx_req` out 1: transmit request. The host starts on the rising edge.
- `led_state` in 3: [2]=caps, [1]=num, [0]=scroll. Sampled when `led_update`=1.
- `led_update` in 1: pulse, request an LED update.
- `key_code` out 8: head-of-FIFO scan code.
- `key_ext` out 1: head event had an E0 prefix.
- `key_break` out 1: head event is a release (F0 prefix).
- `key_valid` out 1: FIFO not empty.
- `key_pop` in 1: pop the head. Ignored when `key_valid`=0.
- `overrun` out 1: sticky; an event was dropped because the FIFO was full. Cleared only by `rst`.
- `cmd_busy` out 1: LED command sequence in progress.
- `cmd_error` out 1: one-cycle pulse, LED command aborted.

## Operation
- **Parser FSM states:** P_IDLE, P_E0, P_F0, P_E0F0, P_SKIP. Bytes are processed only on cycles with `rx_ready`=1.
  - P_IDLE: E0→P_E0; F0→P_F0; E1→P_SKIP with skip counter=7; status bytes (00, AA, EE, FA, FE, FF) are discarded and the state stays P_IDLE; any other byte pushes event {ext=0, brk=0, code}.
  - P_E0: F0→P_E0F0; status byte→P_IDLE, no event; E0 stays in P_E0; any other byte pushes {1,0,code}→P_IDLE.
  - P_F0: pushes {0,1,code}→P_IDLE. A status byte aborts to P_IDLE with no event.
  - P_E0F0: pushes {1,1,code}→P_IDLE. A status byte aborts to P_IDLE with no event.
  - P_SKIP: each byte decrements the counter; at 0→P_IDLE. This swallows the 8-byte Pause sequence with no events.
- **Bytes consumed by the command FSM:** while the command FSM is in C_WAIT_FA1 or C_WAIT_FA2, FA and FE are consumed there and do not reach the parser. Other bytes go to the parser normally.
- **FIFO:** each entry is {ext, brk, code}, 10 bits. Outputs show the head combinationally from storage (FWFT).
  - Push when full drops the new event and sets `overrun`.
  - Push and pop in the same cycle while full: the pop is applied and the push is accepted.
  - Push and pop in the same cycle while empty: the push is accepted and the pop is ignored.
- **Command FSM states:** C_IDLE, C_SEND_ED, C_WAIT_ACK1, C_WAIT_FA1, C_SEND_LED, C_WAIT_ACK2, C_WAIT_FA2.
  - `led_update` latches `led_state` into a pending register and sets a pending flag. A `led_update` during busy overwrites the pending value; one further sequence runs after the current one completes.
  - C_IDLE with pending set: clear pending, load the LED byte {5'b0, caps, num, scroll}, go to C_SEND_ED.
  - C_SEND_ED: `tx_data`=ED, `tx_req`=1 → C_WAIT_ACK1.
  - C_WAIT_ACK1: `tx_req` stays 1 until `tx_ready`, then drops to 0 → C_WAIT_FA1.
  - C_WAIT_FA1: received FA → C_SEND_LED; FE or timeout → abort.
  - C_SEND_LED and C_WAIT_ACK2 behave like C_SEND_ED and C_WAIT_ACK1, using the LED byte.
  - C_WAIT_FA2: FA → C_IDLE; FE or timeout → abort.
- **Timeout counter:** reloads on entry to each wait state and counts down. On reaching 0, the FSM aborts.
- **Abort:** `tx_req`=0, `cmd_error` pulses for 1 cycle, → C_IDLE. A pending request, if any, then runs.
- `cmd_busy` = (state≠C_IDLE).

## Timing
- Reset values:
  - `tx_req`=0, `tx_data`=00, `key_valid`=0.
  - `key_code`/`key_ext`/`key_break`=0 (FIFO storage cleared).
  - `overrun`=0, `cmd_busy`=0, `cmd_error`=0.
  - FSMs in P_IDLE and C_IDLE; pending flag cleared.
- Reset mid-sequence aborts everything at once: `tx_req` low the next cycle; the FIFO is emptied.
- Event latency: `rx_ready` high at edge N (final byte of a sequence) → `key_valid`=1 after edge N+1 (i.e. during cycle N+1).
- Pop: `key_pop` at edge N → the next head, or `key_valid`=0, is visible after edge N.
- Rising edge of `tx_req` appears one cycle after the FSM leaves C_IDLE or C_WAIT_FA1.
- `tx_req` has ≥1 low cycle between the two bytes of a sequence (guaranteed by the FA wait).
- `tx_data` is registered and never changes while `tx_req`=1.

## Test plan
- Bytes 1C, F0 1C → two events: {0,0,1C}, then {0,1,1C}; `key_valid` falls after 2 pops.
- E0 75, E0 F0 75 → events {1,0,75}, {1,1,75}. Pause (E1 14 77 E1 F0 14 F0 77) then 29 → only {0,0,29}.
- FIFO_DEPTH=4, push 5 makes with no pops → 4 stored, `overrun`=1. Simultaneous push+pop when full → count stays 4, no new overrun.
- `led_update` with `led_state`=3'b101 → `tx_data`=ED with `tx_req` rising; `tx_ready`, rx FA → `tx_data`=05; `tx_ready`, rx FA → `cmd_busy`=0. No key events generated.
- In C_WAIT_FA1 rx FE → `cmd_error` pulse, C_IDLE. Separately, no ACK for ACK_TIMEOUT cycles → `cmd_error` pulse.
- `rst` asserted during C_WAIT_ACK2 with 2 events queued → `tx_req`=0, `key_valid`=0, `cmd_busy`=0 the next cycle.
